// File: rtl/pipeline_hazard_ctrl.sv
// Decode-to-execute issue control: register scoreboard,
// RAW/WAW/structural hazard gating and LOAD/STORE port occupancy.
module pipeline_hazard_ctrl #(
  parameter int MEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [3:0]  dec_opcode,
  input  logic [3:0]  dec_destReg,
  input  logic [3:0]  dec_srcReg1,
  input  logic [3:0]  dec_srcReg2,
  input  logic        wb_valid,
  input  logic [3:0]  wb_destReg,
  output logic        issue,
  output logic        stall,
  output logic        inuse1,
  output logic        inuse2,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_done,
  output logic [15:0] scoreboard,
  output logic [7:0]  stall_cnt
);

  typedef enum logic {
    S_IDLE,
    S_MEM
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hF;
  localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_done_q, mem_done_d;
  logic [15:0] sb_q, sb_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;

  logic        is_load, is_store, is_alu;
  logic        use1, use2, wdest;
  logic        hazard;
  logic [15:0] clr, set, eff;

  // Classify the decoded opcode into operand usage.
  always_comb begin
    is_load  = (dec_opcode == OP_LOAD);
    is_store = (dec_opcode == OP_STORE);
    is_alu   = ~is_load & ~is_store &
               (dec_opcode != OP_NOP);
    use1     = is_alu | is_store;
    use2     = is_alu;
    wdest    = is_alu | is_load;
  end

  // Effective busy bits: a same-cycle writeback frees its register.
  always_comb begin
    clr = '0;
    if (wb_valid) clr[wb_destReg] = 1'b1;
    eff    = sb_q & ~clr;
    inuse1 = eff[dec_srcReg1];
    inuse2 = eff[dec_srcReg2];
  end

  // Hazard detection and zero-latency issue decision.
  always_comb begin
    hazard = (use1 & inuse1) |
             (use2 & inuse2) |
             (wdest & eff[dec_destReg]) |
             (state_q != S_IDLE);
    issue  = dec_valid & ~hazard & ~rst;
    stall  = dec_valid & ~issue;
  end

  // Scoreboard update; set is OR-ed last so it wins over a clear.
  always_comb begin
    set = '0;
    if (issue & wdest) set[dec_destReg] = 1'b1;
    sb_d = (sb_q & ~clr) | set;
  end

  // Memory-port occupancy sequencing and registered port outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (issue & (is_load | is_store)) begin
          state_d    = S_MEM;
          cnt_d      = LAT_M1;
          mem_req_d  = 1'b1;
          mem_we_d   = is_store;
          mem_done_d = (LAT_M1 == 4'd1);
        end
      end
      S_MEM: begin
        if (cnt_q == 4'd1) begin
          state_d   = S_IDLE;
          cnt_d     = 4'd0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          mem_done_d = (cnt_q == 4'd2);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating count of stalled decode cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 8'hFF)
      stall_cnt_d = stall_cnt_q + 8'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_done_q  <= 1'b0;
      sb_q        <= '0;
      stall_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_done_q  <= mem_done_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_done   = mem_done_q;
  assign scoreboard = sb_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [3:0]  dec_opcode;
  logic [3:0]  dec_destReg;
  logic [3:0]  dec_srcReg1;
  logic [3:0]  dec_srcReg2;
  logic        wb_valid;
  logic [3:0]  wb_destReg;
  logic        issue, stall, inuse1, inuse2;
  logic        mem_req, mem_we, mem_done;
  logic [15:0] scoreboard;
  logic [7:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb_exp[$];
  logic [2:0]  mem_exp[$];
  logic [15:0] e16;
  logic [2:0]  e3;

  pipeline_hazard_ctrl #(.MEM_LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .dec_destReg(dec_destReg),
    .dec_srcReg1(dec_srcReg1), .dec_srcReg2(dec_srcReg2),
    .wb_valid(wb_valid), .wb_destReg(wb_destReg),
    .issue(issue), .stall(stall),
    .inuse1(inuse1), .inuse2(inuse2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_done(mem_done),
    .scoreboard(scoreboard), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2);
    dec_valid   = v;
    dec_opcode  = op;
    dec_destReg = d;
    dec_srcReg1 = s1;
    dec_srcReg2 = s2;
  endtask

  task automatic wb(input logic v, input logic [3:0] r);
    wb_valid   = v;
    wb_destReg = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    wb(1'b0, 4'h0);
    cyc(); cyc(); #1;
    checks++;
    if (scoreboard !== 16'h0) begin errors++;
      $display("FAIL rst_sb got %h want 0000", scoreboard); end
    checks++;
    if (mem_req !== 1'b0 || mem_done !== 1'b0) begin errors++;
      $display("FAIL rst_mem got %b%b want 00", mem_req, mem_done); end
    checks++;
    if (stall_cnt !== 8'd0) begin errors++;
      $display("FAIL rst_stallcnt got %0d want 0", stall_cnt); end
    // LOAD, then reset for 2 cycles while the port is busy
    cyc(); rst = 1'b0; drive(1'b1, 4'hE, 4'd4, 4'd0, 4'd0); #1;
    checks++;
    if (issue !== 1'b1) begin errors++;
      $display("FAIL rst_load_issue got %b want 1", issue); end
    cyc(); rst = 1'b1; drive(1'b1, 4'h1, 4'd9, 4'd0, 4'd0); #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++;
      $display("FAIL rst_midmem_req got %b want 1", mem_req); end
    checks++;
    if (issue !== 1'b0) begin errors++;
      $display("FAIL rst_issue0 got %b want 0", issue); end
    cyc(); #1;
    checks++;
    if (issue !== 1'b0) begin errors++;
      $display("FAIL rst_issue_forced got %b want 0", issue); end
    checks++;
    if (mem_done !== 1'b0) begin errors++;
      $display("FAIL rst_nodone got %b want 0", mem_done); end
    cyc(); rst = 1'b0; drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); #1;
    checks++;
    if (scoreboard !== 16'h0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL rst_after got sb=%h req=%b want 0000 0",
               scoreboard, mem_req); end
    checks++;
    if (mem_done !== 1'b0 || stall_cnt !== 8'd0) begin errors++;
      $display("FAIL rst_after2 got done=%b cnt=%0d want 0 0",
               mem_done, stall_cnt); end
  endtask

  task automatic test_raw();
    cyc(); drive(1'b1, 4'h1, 4'd3, 4'd1, 4'd2); #1;
    checks++;
    if (issue !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL raw_first got issue=%b stall=%b want 1 0",
               issue, stall); end
    sb_exp.push_back(16'h0008);
    cyc(); drive(1'b1, 4'h2, 4'd5, 4'd3, 4'd4); #1;
    e16 = sb_exp.pop_front();
    checks++;
    if (scoreboard !== e16) begin errors++;
      $display("FAIL raw_sb1 got %h want %h", scoreboard, e16); end
    checks++;
    if (stall !== 1'b1 || inuse1 !== 1'b1 || issue !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall got s=%b u1=%b i=%b want 1 1 0",
               stall, inuse1, issue); end
    cyc(); wb(1'b1, 4'd3); #1;
    checks++;
    if (issue !== 1'b1 || inuse1 !== 1'b0) begin errors++;
      $display("FAIL raw_bypass got i=%b u1=%b want 1 0",
               issue, inuse1); end
    sb_exp.push_back(16'h0020);
    cyc(); drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); wb(1'b0, 4'd0); #1;
    e16 = sb_exp.pop_front();
    checks++;
    if (scoreboard !== e16) begin errors++;
      $display("FAIL raw_sb2 got %h want %h", scoreboard, e16); end
    cyc(); wb(1'b1, 4'd5);
    cyc(); wb(1'b0, 4'd0); #1;
    checks++;
    if (scoreboard !== 16'h0) begin errors++;
      $display("FAIL raw_clear got %h want 0000", scoreboard); end
  endtask

  task automatic test_waw();
    cyc(); drive(1'b1, 4'h3, 4'd7, 4'd0, 4'd0); #1;
    cyc(); drive(1'b1, 4'h3, 4'd7, 4'd1, 4'd2); #1;
    checks++;
    if (stall !== 1'b1 || inuse1 !== 1'b0 || inuse2 !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall got s=%b u=%b%b want 1 00",
               stall, inuse1, inuse2); end
    cyc(); #1;
    checks++;
    if (issue !== 1'b0) begin errors++;
      $display("FAIL waw_hold got %b want 0", issue); end
    cyc(); wb(1'b1, 4'd7); #1;
    checks++;
    if (issue !== 1'b1) begin errors++;
      $display("FAIL waw_issue got %b want 1", issue); end
    sb_exp.push_back(16'h0080);
    cyc(); drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); wb(1'b0, 4'd0); #1;
    e16 = sb_exp.pop_front();
    checks++;
    if (scoreboard !== e16) begin errors++;
      $display("FAIL waw_setwins got %h want %h", scoreboard, e16); end
    cyc(); wb(1'b1, 4'd7);
    cyc(); wb(1'b0, 4'd0);
  endtask

  task automatic test_load();
    cyc(); drive(1'b1, 4'hE, 4'd4, 4'd9, 4'd9); #1;
    checks++;
    if (issue !== 1'b1) begin errors++;
      $display("FAIL ld_issue got %b want 1", issue); end
    mem_exp.push_back(3'b100);
    mem_exp.push_back(3'b101);
    mem_exp.push_back(3'b000);
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(1'b1, 4'h5, 4'd8, 4'd1, 4'd2); #1;
      e3 = mem_exp.pop_front();
      checks++;
      if ({mem_req, mem_we, mem_done} !== e3) begin errors++;
        $display("FAIL ld_mem%0d got %b want %b", k,
                 {mem_req, mem_we, mem_done}, e3); end
      checks++;
      if (issue !== (k == 2)) begin errors++;
        $display("FAIL ld_issue%0d got %b want %b", k, issue, k == 2);
      end
      checks++;
      if (scoreboard !== 16'h0010) begin errors++;
        $display("FAIL ld_sb%0d got %h want 0010", k, scoreboard); end
    end
    sb_exp.push_back(16'h0110);
    cyc(); drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); #1;
    e16 = sb_exp.pop_front();
    checks++;
    if (scoreboard !== e16) begin errors++;
      $display("FAIL ld_sbafter got %h want %h", scoreboard, e16); end
    cyc(); wb(1'b1, 4'd4);
    cyc(); wb(1'b1, 4'd8);
    cyc(); wb(1'b0, 4'd0);
  endtask

  task automatic test_store();
    cyc(); drive(1'b1, 4'h4, 4'd6, 4'd0, 4'd0);
    cyc(); drive(1'b1, 4'hF, 4'd2, 4'd6, 4'd0); #1;
    checks++;
    if (stall !== 1'b1 || inuse1 !== 1'b1) begin errors++;
      $display("FAIL st_stall got s=%b u1=%b want 1 1",
               stall, inuse1); end
    cyc(); #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++;
      $display("FAIL st_nomem got %b want 0", mem_req); end
    cyc(); wb(1'b1, 4'd6); #1;
    checks++;
    if (issue !== 1'b1) begin errors++;
      $display("FAIL st_issue got %b want 1", issue); end
    mem_exp.push_back(3'b110);
    mem_exp.push_back(3'b111);
    mem_exp.push_back(3'b000);
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); wb(1'b0, 4'd0); #1;
      e3 = mem_exp.pop_front();
      checks++;
      if ({mem_req, mem_we, mem_done} !== e3) begin errors++;
        $display("FAIL st_mem%0d got %b want %b", k,
                 {mem_req, mem_we, mem_done}, e3); end
      checks++;
      if (scoreboard !== 16'h0) begin errors++;
        $display("FAIL st_sb%0d got %h want 0000", k, scoreboard); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      cyc(); drive(1'b1, 4'h6, 4'(k), 4'd0, 4'd0); #1;
      checks++;
      if (issue !== 1'b1) begin errors++;
        $display("FAIL b2b_issue%0d got %b want 1", k, issue); end
    end
    sb_exp.push_back(16'h000E);
    cyc(); drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); #1;
    e16 = sb_exp.pop_front();
    checks++;
    if (scoreboard !== e16) begin errors++;
      $display("FAIL b2b_sb got %h want %h", scoreboard, e16); end
  endtask

  task automatic test_stall_sat();
    int exp_cnt;
    cyc(); rst = 1'b1; drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    wb(1'b0, 4'd0);
    cyc(); rst = 1'b0; drive(1'b1, 4'h1, 4'd10, 4'd0, 4'd0); #1;
    checks++;
    if (issue !== 1'b1) begin errors++;
      $display("FAIL sat_issue got %b want 1", issue); end
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); drive(1'b1, 4'h1, 4'd11, 4'd10, 4'd0); #1;
      if (i == 0 || i == 1 || i == 254 || i == 255 ||
          i == 256 || i == 299) begin
        checks++;
        if (stall_cnt !== 8'(exp_cnt)) begin errors++;
          $display("FAIL sat_cnt%0d got %0d want %0d",
                   i, stall_cnt, exp_cnt); end
      end
      if (exp_cnt < 255) exp_cnt++;
    end
    cyc(); drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0); #1;
    checks++;
    if (stall_cnt !== 8'd255) begin errors++;
      $display("FAIL sat_final got %0d want 255", stall_cnt); end
    cyc(); wb(1'b1, 4'd10);
    cyc(); wb(1'b0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_load();
    test_store();
    test_back_to_back();
    test_stall_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
